apb_protocol_monitor: RTL
=========================

Name: apb_protocol_monitor

Overview:
- Passive, synthesizable APB protocol monitor/checker. It generalises the fixed "≤5 wait-states" assertion into RTL that stays with the DUT in simulation and emulation.
- It snoops an APB bus with a multi-bit PSEL and tracks SETUP/ACCESS phases. It checks a configurable wait-state limit, phase ordering, signal stability and PSEL one-hot encoding.
- It reports sticky error flags, per-error pulses and saturating transfer statistics.
- It drives nothing onto the bus.

Parameters:
- ADDR_W, 16, PADDR width
- DATA_W, 32, PWDATA width
- NUM_SEL, 4, number of PSEL lines (slaves), ≥1
- MAX_WAIT, 5, maximum legal wait states per transfer (0..255)
- CNT_W, 16, width of statistics counters

Ports:
- pclk  in  1  bus clock, all logic on rising edge
- preset  in  1  asynchronous, active-high reset
- psel  in  NUM_SEL  snooped slave selects
- penable  in  1  snooped enable
- pwrite  in  1  snooped direction
- paddr  in  ADDR_W  snooped address
- pwdata  in  DATA_W  snooped write data
- pready  in  1  snooped ready
- clr  in  1  synchronous clear of counters, sticky flags and max_wait_seen
- err_sticky  out  5  sticky error flags (bit map below)
- err_pulse  out  5  one-cycle flags for errors detected at the last edge
- wait_cnt  out  8  wait states elapsed in the current transfer
- max_wait_seen  out  8  largest wait count of any completed transfer
- xfer_cnt  out  CNT_W  completed transfers (saturating)
- wr_cnt  out  CNT_W  completed write transfers (saturating)
- err_cnt  out  CNT_W  edges with any err_pulse bit set (saturating)

Behaviour:
- Error bit map:
  - [0] wait timeout
  - [1] PENABLE high outside a transfer
  - [2] PADDR/PWRITE/PWDATA/PSEL changed during ACCESS
  - [3] PSEL not one-hot (more than one bit set)
  - [4] SETUP aborted (not followed by ACCESS)
- Reset (preset=1, async): state=IDLE, every output and internal register 0.
- All outputs are registered. A violation sampled at edge N is visible from edge N until edge N+1.
- Inputs are sampled at each rising pclk edge. The FSM is IDLE/SETUP/ACCESS.
- IDLE:
  - |psel & !penable → SETUP. Capture paddr, pwrite, pwdata, psel.
  - penable=1 → err[1], stay IDLE.
- SETUP (cycle after a setup cycle):
  - Requires |psel & penable with all captured values unchanged.
  - If that holds: wait_cnt=0. If pready=1, complete the transfer and go to IDLE; else go to ACCESS and set wait_cnt=1.
  - If it does not hold: err[4]. The sampled cycle is re-evaluated as IDLE (a new setup goes to SETUP).
- ACCESS:
  - Requires psel/penable high and captured values stable; otherwise err[2] and → IDLE, with no completion.
  - pready=1: complete, → IDLE.
  - pready=0: wait_cnt++, saturating at 255.
- Timeout: err[0] asserts once per transfer, on the edge where wait_cnt would become MAX_WAIT+1. Monitoring continues until pready, and wait_cnt keeps counting. With MAX_WAIT=0, any ACCESS with pready=0 times out.
- Completion actions:
  - xfer_cnt++.
  - wr_cnt++ if pwrite.
  - max_wait_seen = max(max_wait_seen, wait_cnt).
  - wait_cnt is held until the next SETUP.
- err[3] is evaluated every edge where psel has ≥2 bits set. In that case no SETUP is entered.
- err_sticky |= err_pulse each edge. err_cnt++ when err_pulse != 0.
- All counters saturate at all-ones and never wrap.
- clr=1 clears the counters, err_sticky and max_wait_seen. Errors detected on the same edge still set err_pulse, but the sticky flags and counters stay cleared (clear wins). The FSM is unaffected by clr.
- Back-to-back transfers: a completion edge followed immediately by a new setup is legal and takes no idle cycle.
- preset mid-transfer: the block returns to IDLE immediately. The transfer is neither counted nor flagged.

Test Plan:
- Write with 3 wait states, MAX_WAIT=5 → no errors; xfer_cnt=1, wr_cnt=1, max_wait_seen=3.
- Read with pready low for 6 access cycles, MAX_WAIT=5 → err_pulse[0] for exactly one cycle on the 6th low-pready edge; err_cnt=1; completion still counted, max_wait_seen=6.
- penable=1 with psel=0 → err_pulse=5'b00010, err_sticky[1]=1; then clr=1 → err_sticky=0, counters=0.
- paddr changes 0x0010→0x0014 mid-ACCESS → err[2]; transfer not counted; the next clean transfer counts normally.
- psel=4'b0011 → err[3]. A setup cycle followed by psel=0 → err[4]. preset pulsed mid-ACCESS → all outputs 0, and the next transfer is monitored from IDLE.
- 70000 back-to-back zero-wait transfers with CNT_W=16 → xfer_cnt saturates at 0xFFFF.

Source files
------------

// File: rtl/apb_protocol_monitor.sv
// Passive APB checker: phase tracking, wait-state limit, stability
// and PSEL encoding checks with sticky flags and saturating statistics.
module apb_protocol_monitor #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 32,
  parameter int NUM_SEL  = 4,
  parameter int MAX_WAIT = 5,
  parameter int CNT_W    = 16
) (
  input  logic               pclk,
  input  logic               preset,
  input  logic [NUM_SEL-1:0] psel,
  input  logic               penable,
  input  logic               pwrite,
  input  logic [ADDR_W-1:0]  paddr,
  input  logic [DATA_W-1:0]  pwdata,
  input  logic               pready,
  input  logic               clr,
  output logic [4:0]         err_sticky,
  output logic [4:0]         err_pulse,
  output logic [7:0]         wait_cnt,
  output logic [7:0]         max_wait_seen,
  output logic [CNT_W-1:0]   xfer_cnt,
  output logic [CNT_W-1:0]   wr_cnt,
  output logic [CNT_W-1:0]   err_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  state_t state, state_nx;

  logic [NUM_SEL-1:0] cap_sel;
  logic [ADDR_W-1:0]  cap_addr;
  logic [DATA_W-1:0]  cap_data;
  logic               cap_wr;
  logic               timed_out, timed_out_nx;
  logic [7:0]         wait_nx;
  logic [4:0]         err;
  logic               multi, hold;
  logic               idle_eval, capture, complete;

  assign multi = $countones(psel) > 1;

  assign hold = |psel && penable
             && psel == cap_sel
             && paddr == cap_addr
             && pwdata == cap_data
             && pwrite == cap_wr;

  always_comb begin
    state_nx     = state;
    wait_nx      = wait_cnt;
    timed_out_nx = timed_out;
    err          = '0;
    err[3]       = multi;
    idle_eval    = 1'b0;
    capture      = 1'b0;
    complete     = 1'b0;
    unique case (state)
      SETUP: begin
        if (hold) begin
          timed_out_nx = (MAX_WAIT == 0) && !pready;
          err[0]       = timed_out_nx;
          wait_nx      = pready ? 8'd0 : 8'd1;
          complete     = pready;
          state_nx     = pready ? IDLE : ACCESS;
        end else begin
          err[4]    = 1'b1;
          idle_eval = 1'b1;
        end
      end
      ACCESS: begin
        if (!hold) begin
          err[2]   = 1'b1;
          state_nx = IDLE;
        end else if (pready) begin
          complete = 1'b1;
          state_nx = IDLE;
        end else begin
          if (wait_cnt != 8'hff)
            wait_nx = wait_cnt + 8'd1;
          // fires when the count would step past the limit, once only
          if (wait_cnt == 8'(MAX_WAIT) && !timed_out) begin
            err[0]       = 1'b1;
            timed_out_nx = 1'b1;
          end
        end
      end
      default: idle_eval = 1'b1;
    endcase
    if (idle_eval) begin
      state_nx = IDLE;
      if (penable) begin
        err[1] = 1'b1;
      end else if (|psel && !multi) begin
        state_nx = SETUP;
        capture  = 1'b1;
      end
    end
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state     <= IDLE;
      cap_sel   <= '0;
      cap_addr  <= '0;
      cap_data  <= '0;
      cap_wr    <= 1'b0;
      timed_out <= 1'b0;
      wait_cnt  <= '0;
      err_pulse <= '0;
    end else begin
      state     <= state_nx;
      timed_out <= timed_out_nx;
      wait_cnt  <= wait_nx;
      err_pulse <= err;
      if (capture) begin
        cap_sel  <= psel;
        cap_addr <= paddr;
        cap_data <= pwdata;
        cap_wr   <= pwrite;
      end
    end
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      err_sticky    <= '0;
      max_wait_seen <= '0;
      xfer_cnt      <= '0;
      wr_cnt        <= '0;
      err_cnt       <= '0;
    end else if (clr) begin
      err_sticky    <= '0;
      max_wait_seen <= '0;
      xfer_cnt      <= '0;
      wr_cnt        <= '0;
      err_cnt       <= '0;
    end else begin
      err_sticky <= err_sticky | err;
      if (|err && err_cnt != '1)
        err_cnt <= err_cnt + 1'b1;
      if (complete) begin
        if (xfer_cnt != '1)
          xfer_cnt <= xfer_cnt + 1'b1;
        if (cap_wr && wr_cnt != '1)
          wr_cnt <= wr_cnt + 1'b1;
        if (wait_nx > max_wait_seen)
          max_wait_seen <= wait_nx;
      end
    end
  end

endmodule
